// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one ROM request at a time, buffers the response
// for decode, and handles redirects, ROM timeouts and pc wrap-around.
module inst_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce,
   output logic [63:0] rom_addr,
   input  logic        rom_valid,
   input  logic [31:0] rom_inst,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [63:0] id_pc,
   output logic [31:0] id_inst,
   output logic        fetch_err
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [63:0] RESET_PC_A = RESET_PC & ~64'h3;

   localparam logic [2:0] S_REQ  = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_HOLD = 3'd2;
   localparam logic [2:0] S_DROP = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [63:0]      pc_q, pc_d;
   logic [63:0]      rom_addr_q, rom_addr_d;
   logic [63:0]      id_pc_q, id_pc_d;
   logic [31:0]      id_inst_q, id_inst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             id_valid_q, id_valid_d;
   logic             fetch_err_q, fetch_err_d;
   logic [CNT_W-1:0] cnt_inc_c;
   logic [63:0]      redir_pc_c;

   assign cnt_inc_c  = cnt_q + CNT_W'(1);
   assign redir_pc_c = redirect_pc & ~64'h3;

   // Next-state and datapath decisions; redirect overrides the sequential pc step.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_REQ: begin
            cnt_d   = '0;
            state_d = redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (rom_valid) begin
               if (redirect) begin
                  state_d = S_REQ;
               end else begin
                  id_inst_d = rom_inst;
                  id_pc_d   = rom_addr_q;
                  state_d   = S_HOLD;
               end
            end else if (redirect) begin
               cnt_d   = '0;
               state_d = S_DROP;
            end else begin
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == TIMEOUT_C) state_d = S_ERR;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               state_d = S_REQ;
            end else if (id_ready) begin
               pc_d    = pc_q + 64'd4;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (rom_valid) begin
               state_d = S_REQ;
            end else begin
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == TIMEOUT_C) state_d = S_ERR;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase

      if (redirect && (state_q != S_ERR)) pc_d = redir_pc_c;

      // The request address is latched on the way into REQ and then held until the response.
      rom_addr_d  = (state_d == S_REQ) ? pc_d : rom_addr_q;
      id_valid_d  = (state_d == S_HOLD);
      fetch_err_d = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC_A;
         rom_addr_q  <= RESET_PC_A;
         id_pc_q     <= '0;
         id_inst_q   <= '0;
         cnt_q       <= '0;
         id_valid_q  <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rom_addr_q  <= rom_addr_d;
         id_pc_q     <= id_pc_d;
         id_inst_q   <= id_inst_d;
         cnt_q       <= cnt_d;
         id_valid_q  <= id_valid_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // Request pulse decodes the state register so it fires in the first cycle out of reset.
   assign rom_ce    = (state_q == S_REQ) && !rst;
   assign rom_addr  = rom_addr_q;
   assign id_valid  = id_valid_q;
   assign id_pc     = id_pc_q;
   assign id_inst   = id_inst_q;
   assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed cycle/address expectations.
module tb_inst_fetch;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce;
   logic [63:0] rom_addr;
   logic        rom_valid = 1'b0;
   logic [31:0] rom_inst  = 32'hDEAD_BEEF;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [31:0] id_inst;
   logic        fetch_err;

   inst_fetch #(.RESET_PC(64'h0), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .rom_ce(rom_ce), .rom_addr(rom_addr),
      .rom_valid(rom_valid), .rom_inst(rom_inst),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_inst(id_inst),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int base     = 0;
   int err_cyc  = -1;
   bit started  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc - base);
   endtask

   // ROM responder: single outstanding request, fixed latency (0 = never answers).
   int          rom_lat = 5;
   bit          rom_pend = 1'b0;
   int          rom_due = 0;
   logic [63:0] rom_a = '0;

   always @(negedge clk) begin
      if (rst) rom_pend = 1'b0;
      else if (rom_ce && rom_lat != 0) begin
         rom_pend = 1'b1;
         rom_due  = cyc + rom_lat;
         rom_a    = rom_addr;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rom_pend && cyc == rom_due) begin
         rom_valid = 1'b1;
         rom_inst  = {16'hC0DE, rom_a[15:0]};
         rom_pend  = 1'b0;
      end else begin
         rom_valid = 1'b0;
         rom_inst  = 32'hDEAD_BEEF;
      end
   end

   // Transaction-level model: an issue slot, an outstanding request that is either
   // wanted or to be discarded, a one-entry buffer to decode, and a sticky error.
   bit          m_err, m_issue, m_busy, m_keep, m_buf, nxt_issue;
   logic [63:0] m_pc, m_req_addr, m_buf_pc;
   logic [31:0] m_buf_inst;
   int          m_age;

   always @(posedge clk) begin
      if (rst) begin
         started = 1'b1;
         m_err = 0; m_issue = 1; m_busy = 0; m_keep = 0; m_buf = 0;
         m_buf_pc = '0; m_buf_inst = '0; m_pc = '0; m_req_addr = '0; m_age = 0;
      end else if (!m_err) begin
         nxt_issue = 0;
         if (m_issue) begin
            m_busy = 1; m_keep = !redirect; m_age = 0;
         end else if (m_busy) begin
            if (rom_valid) begin
               m_busy = 0;
               if (m_keep && !redirect) begin
                  m_buf = 1; m_buf_pc = m_req_addr; m_buf_inst = rom_inst;
               end else nxt_issue = 1;
            end else if (redirect && m_keep) begin
               m_keep = 0; m_age = 0;
            end else begin
               m_age++;
               if (m_age == int'(TMO)) begin m_err = 1; m_busy = 0; end
            end
         end else if (m_buf) begin
            if (redirect || id_ready) begin
               m_buf = 0; nxt_issue = 1;
               if (!redirect) m_pc = m_pc + 64'd4;
            end
         end
         if (redirect) m_pc = redirect_pc & ~64'h3;
         if (nxt_issue) m_req_addr = m_pc;
         m_issue = nxt_issue;
      end
   end

   // Event logs relative to the last reset release.
   int          ce_cyc[$], iv_cyc[$];
   logic [63:0] ce_addr[$], iv_pc[$];
   logic [31:0] iv_inst[$];

   always @(negedge clk) begin
      if (started) begin
         check("rom_ce",    64'(rom_ce),    64'(m_issue && !rst));
         check("rom_addr",  rom_addr,       m_req_addr);
         check("id_valid",  64'(id_valid),  64'(m_buf));
         check("id_pc",     id_pc,          m_buf_pc);
         check("id_inst",   64'(id_inst),   64'(m_buf_inst));
         check("fetch_err", 64'(fetch_err), 64'(m_err));
         if (!rst) begin
            if (rom_ce) begin ce_cyc.push_back(cyc - base); ce_addr.push_back(rom_addr); end
            if (id_valid) begin
               iv_cyc.push_back(cyc - base); iv_pc.push_back(id_pc); iv_inst.push_back(id_inst);
            end
            if (fetch_err && err_cyc < 0) err_cyc = cyc - base;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0;
      tick(2);
      rst = 1'b0; base = cyc; err_cyc = -1;
      ce_cyc.delete(); ce_addr.delete(); iv_cyc.delete(); iv_pc.delete(); iv_inst.delete();
   endtask

   task automatic chk_ce(input string name, input int idx, input int c, input logic [63:0] a);
      if (idx >= ce_cyc.size()) check({name, "_missing"}, 64'(ce_cyc.size()), 64'(idx + 1));
      else begin
         check({name, "_cyc"}, 64'(ce_cyc[idx]), 64'(c));
         check({name, "_addr"}, ce_addr[idx], a);
      end
   endtask

   task automatic chk_iv(input string name, input int idx, input int c, input logic [63:0] p,
                         input logic [31:0] ins);
      if (idx >= iv_cyc.size()) check({name, "_missing"}, 64'(iv_cyc.size()), 64'(idx + 1));
      else begin
         check({name, "_cyc"}, 64'(iv_cyc[idx]), 64'(c));
         check({name, "_pc"}, iv_pc[idx], p);
         check({name, "_inst"}, 64'(iv_inst[idx]), 64'(ins));
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;

      // Basic fetch, latency 5, decode always ready.
      do_reset();
      check("reset_fetch_err", 64'(fetch_err), 64'h0);
      check("reset_id_valid",  64'(id_valid),  64'h0);
      tick(21);
      check("basic_ce_count", 64'(ce_cyc.size()), 64'd3);
      check("basic_iv_count", 64'(iv_cyc.size()), 64'd3);
      chk_ce("basic_ce0", 0, 0,  64'h0);
      chk_ce("basic_ce1", 1, 7,  64'h4);
      chk_ce("basic_ce2", 2, 14, 64'h8);
      chk_iv("basic_iv0", 0, 6,  64'h0, 32'hC0DE_0000);
      chk_iv("basic_iv1", 1, 13, 64'h4, 32'hC0DE_0004);
      chk_iv("basic_iv2", 2, 20, 64'h8, 32'hC0DE_0008);

      // Backpressure: decode stalls 10 cycles past the first id_valid.
      do_reset();
      id_ready = 1'b0;
      tick(16);
      id_ready = 1'b1;
      tick(2);
      check("bp_iv_count", 64'(iv_cyc.size()), 64'd11);
      for (int i = 0; i < 11; i++) chk_iv("bp_hold", i, 6 + i, 64'h0, 32'hC0DE_0000);
      check("bp_ce_count", 64'(ce_cyc.size()), 64'd2);
      chk_ce("bp_next", 1, 17, 64'h4);

      // Redirect while waiting: response dropped, refetch from aligned target.
      do_reset();
      tick(2);
      redirect = 1'b1; redirect_pc = 64'h103;
      tick(1);
      redirect = 1'b0;
      tick(11);
      check("rw_iv_count", 64'(iv_cyc.size()), 64'd1);
      chk_ce("rw_ce", 1, 6, 64'h100);
      chk_iv("rw_iv", 0, 12, 64'h100, 32'hC0DE_0100);

      // Redirect in the same cycle as rom_valid.
      do_reset();
      tick(5);
      redirect = 1'b1; redirect_pc = 64'h200;
      tick(1);
      redirect = 1'b0;
      tick(7);
      chk_ce("rv_ce", 1, 6, 64'h200);
      check("rv_iv_count", 64'(iv_cyc.size()), 64'd1);
      chk_iv("rv_iv", 0, 12, 64'h200, 32'hC0DE_0200);

      // Redirect while holding an unaccepted instruction.
      do_reset();
      id_ready = 1'b0;
      tick(7);
      redirect = 1'b1; redirect_pc = 64'h300;
      tick(1);
      redirect = 1'b0; id_ready = 1'b1;
      tick(1);
      check("rh_iv_count", 64'(iv_cyc.size()), 64'd2);
      chk_iv("rh_iv1", 1, 7, 64'h0, 32'hC0DE_0000);
      chk_ce("rh_ce", 1, 8, 64'h300);

      // Timeout: ROM silent; redirect in ERR must be ignored.
      do_reset();
      rom_lat = 0;
      tick(12);
      redirect = 1'b1; redirect_pc = 64'h400;
      tick(1);
      redirect = 1'b0;
      tick(7);
      check("to_err_cyc", 64'(err_cyc), 64'd9);
      check("to_ce_count", 64'(ce_cyc.size()), 64'd1);
      check("to_err_level", 64'(fetch_err), 64'h1);
      do_reset();
      rom_lat = 5;
      tick(1);
      check("to_clear_err", 64'(err_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      chk_ce("to_restart", 0, 0, 64'h0);

      // Wrap-around of the sequential pc.
      do_reset();
      redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      tick(1);
      redirect = 1'b0;
      tick(13);
      chk_ce("wrap_ce1", 1, 6, 64'hFFFF_FFFF_FFFF_FFFC);
      chk_iv("wrap_iv", 0, 12, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DE_FFFC);
      chk_ce("wrap_ce2", 2, 13, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- RESET_PC, 64'h0, fetch address after reset; bits [1:0] treated as 0.
- TIMEOUT, 64, maximum cycles to wait for rom_valid before error; range 8..65535.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rom_ce  out  1  one-cycle fetch request pulse to the instruction ROM.
- rom_addr  out  64  byte address of the request; bits [1:0] always 0.
- rom_valid  in  1  one-cycle response strobe from the ROM.
- rom_inst  in  32  instruction word; valid only while rom_valid=1.
- redirect  in  1  branch/trap redirect strobe.
- redirect_pc  in  64  new fetch address; bits [1:0] ignored.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts the instruction.
- id_pc  out  64  address of the presented instruction.
- id_inst  out  32  presented instruction.
- fetch_err  out  1  sticky ROM timeout flag.

Function
REQ-004 The FSM SHALL have exactly these states: REQ, WAIT, HOLD, DROP, ERR.
REQ-005 REQ SHALL drive rom_ce=1 for exactly one cycle with rom_addr=pc, then go to WAIT; it SHALL go to DROP instead if redirect=1 in that cycle.
REQ-006 rom_addr SHALL be a register loaded only in REQ, held stable from the rom_ce cycle until the rom_valid cycle inclusive.
REQ-007 WAIT + rom_valid=1 SHALL capture id_inst<=rom_inst and id_pc<=rom_addr, then go to HOLD.
REQ-008 id_valid SHALL be 1 only in HOLD, so it rises the cycle after rom_valid.
REQ-009 HOLD with id_valid & id_ready SHALL complete a transfer: pc<=pc+4 (mod 2^64), next state REQ.
REQ-010 HOLD with id_ready=0 SHALL hold id_valid, id_pc and id_inst stable.
REQ-011 The minimum one-cycle HOLD stay SHALL guarantee at least one idle cycle between rom_valid and the next rom_ce; rom_ce SHALL never be asserted while a request is outstanding.
REQ-012 redirect=1 in any non-ERR state SHALL load pc<=(redirect_pc with [1:0]=0); redirect SHALL take priority over the pc+4 increment.
REQ-013 redirect in WAIT (rom_valid=0) or REQ SHALL go to DROP.
REQ-014 DROP SHALL wait for rom_valid and discard rom_inst: no capture, id_valid stays 0; it SHALL then go to REQ.
REQ-015 redirect in WAIT in the same cycle as rom_valid SHALL discard the response and go directly to REQ.
REQ-016 redirect in HOLD SHALL drop id_valid the next cycle and go to REQ; if id_ready=1 in that same cycle, the transfer SHALL count as completed.
REQ-017 redirect in DROP SHALL update pc and remain in DROP.
REQ-018 A wait counter SHALL clear on entry to WAIT/DROP and increment each cycle there without rom_valid.
REQ-019 When the wait counter reaches TIMEOUT, the FSM SHALL enter ERR and set fetch_err=1.
REQ-020 ERR SHALL be terminal until rst: rom_ce=0, id_valid=0, fetch_err=1, and all inputs ignored.
REQ-021 A rom_valid pulse arriving in REQ, HOLD or ERR SHALL be ignored.

Reset
REQ-022 While rst=1: rom_ce=0, id_valid=0, fetch_err=0, id_pc=0, id_inst=0, rom_addr=RESET_PC, pc=RESET_PC, wait counter=0, state=REQ.
REQ-023 The first rom_ce SHALL occur in the first cycle with rst=0.
REQ-024 rst asserted mid-request SHALL abandon it; the bench ROM model is reset with the block.

Verification
REQ-025 A bench SHALL cover these directed scenarios:
- Basic fetch: RESET_PC=0, ROM latency 5, id_ready=1 -> rom_ce at cycles 0, 7, 14; id_pc=0, 4, 8; id_valid high one cycle each at cycles 6, 13, 20.
- Backpressure: id_ready=0 for 10 cycles after id_valid -> id_inst/id_pc stable and no rom_ce; then id_ready=1 -> rom_ce the following cycle with addr=4.
- Redirect in WAIT: redirect_pc=64'h103 two cycles after rom_ce -> the response is dropped (id_valid stays 0); the next rom_ce has rom_addr=64'h100; id_pc=64'h100.
- Redirect with rom_valid in the same cycle: no id_valid; the next cycle is rom_ce with addr=redirect_pc.
- Redirect in HOLD with id_ready=0 -> id_valid falls the next cycle; the next rom_ce goes to redirect_pc.
- Timeout: ROM never responds, TIMEOUT=8 -> fetch_err=1 after 8 WAIT cycles with no further rom_ce; rst clears it and fetch restarts at RESET_PC. Wrap-around: pc=64'hFFFF_FFFF_FFFF_FFFC followed by a transfer -> next rom_addr=0.
